// File: rtl/sprite_pkg.sv
// Shared constants and types for the enemy sprite source/loader pair.
// Geometry and colour depth must agree between the read and write sides.
package sprite_pkg;

    localparam int SPRITE_H    = 64;
    localparam int SPRITE_V    = 64;
    localparam int SPRITE_ADDR = 12;
    localparam int COLOR_DEPTH = 12;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        LOAD       = 2'd2
    } loader_state_t;

endpackage

// File: rtl/enemy_sprite_loader.sv
// Streams pixels from a valid/ready source into the sprite RAM write port,
// optionally only during vertical blanking so a sprite never tears mid-frame.
module enemy_sprite_loader
    import sprite_pkg::*;
#(
    parameter int CD         = COLOR_DEPTH,
    parameter int ADDR       = SPRITE_ADDR,
    parameter int BLANK_ONLY = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   count,
    input  logic            blank,
    input  logic            s_valid,
    input  logic [CD-1:0]   s_data,
    output logic            s_ready,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [CD-1:0]   pixel_in,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0]    ST_IDLE  = IDLE;
    localparam logic [1:0]    ST_WAIT  = WAIT_BLANK;
    localparam logic [1:0]    ST_LOAD  = LOAD;
    localparam logic          GATE_ON_BLANK = (BLANK_ONLY != 0);
    localparam logic [ADDR:0] FULL_SPRITE   = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0] ONE           = {{ADDR{1'b0}}, 1'b1};

    logic [1:0]      state_reg, state_next;
    logic [ADDR-1:0] base_reg, base_next;
    logic [ADDR:0]   total_reg, total_next;
    logic [ADDR:0]   index_reg, index_next;
    logic            we_reg;
    logic            done_reg;
    logic [ADDR-1:0] addr_reg;
    logic [CD-1:0]   pixel_reg;

    logic            blank_ok;
    logic            accept;
    logic            last_beat;
    logic [ADDR:0]   index_plus1;
    logic [ADDR-1:0] write_addr;

    assign blank_ok    = blank || !GATE_ON_BLANK;
    // Held low during reset so upstream never sees a beat taken that is then discarded.
    assign s_ready     = reset_n && (state_reg == ST_LOAD) && !abort && blank_ok;
    assign accept      = s_valid && s_ready;
    assign index_plus1 = index_reg + ONE;
    assign last_beat   = (index_plus1 == total_reg);
    assign write_addr  = base_reg + index_reg[ADDR-1:0];

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        total_next = total_reg;
        index_next = index_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    base_next  = base_addr;
                    total_next = (count == '0) ? FULL_SPRITE : count;
                    index_next = '0;
                    state_next = (GATE_ON_BLANK && !blank) ? ST_WAIT : ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (blank) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept) begin
                    index_next = index_plus1;
                    if (last_beat) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            base_reg  <= '0;
            total_reg <= '0;
            index_reg <= '0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            pixel_reg <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            total_reg <= total_next;
            index_reg <= index_next;
            we_reg    <= accept;
            // done lands with the final write, one cycle after its accept.
            done_reg  <= accept && last_beat;
            if (accept) begin
                addr_reg  <= write_addr;
                pixel_reg <= s_data;
            end
        end
    end

    assign we       = we_reg;
    assign addr_w   = addr_reg;
    assign pixel_in = pixel_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_enemy_sprite_loader.sv
// Drives an ungated and a blank-gated loader with shared stimulus and checks
// every cycle against a per-load behavioural model.
module tb_enemy_sprite_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [12:0] count;
    logic        blank;
    logic        s_valid;
    logic [11:0] s_data;

    logic [1:0]  s_ready_w;
    logic [1:0]  we_w;
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [11:0] addr_w_w [2];
    logic [11:0] pix_w [2];

    int total = 0;
    int bad   = 0;

    // Model: m_busy = a load is open, m_wait = still waiting for first blank.
    bit m_busy [2];
    bit m_wait [2];
    int m_idx [2];
    int m_total [2];
    int m_base [2];
    bit e_we [2];
    bit e_done [2];
    int e_addr [2];
    int e_pix [2];
    bit rdy_q [2];
    int wr_cnt [2];
    int done_cnt [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            enemy_sprite_loader #(
                .CD(12),
                .ADDR(12),
                .BLANK_ONLY(gi)
            ) dut (
                .clk(clk),
                .reset_n(reset_n),
                .start(start),
                .abort(abort),
                .base_addr(base_addr),
                .count(count),
                .blank(blank),
                .s_valid(s_valid),
                .s_data(s_data),
                .s_ready(s_ready_w[gi]),
                .we(we_w[gi]),
                .addr_w(addr_w_w[gi]),
                .pixel_in(pix_w[gi]),
                .busy(busy_w[gi]),
                .done(done_w[gi])
            );
        end
    endgenerate

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit rdy;
            rdy = reset_n && m_busy[m] && !m_wait[m] && !abort && (blank || m == 0);
            rdy_q[m] = rdy;
            check($sformatf("s_ready%0d", m), 32'(s_ready_w[m]), 32'(rdy));
            check($sformatf("we%0d", m), 32'(we_w[m]), 32'(e_we[m]));
            check($sformatf("done%0d", m), 32'(done_w[m]), 32'(e_done[m]));
            check($sformatf("busy%0d", m), 32'(busy_w[m]), 32'(m_busy[m]));
            check($sformatf("addr%0d", m), 32'(addr_w_w[m]), e_addr[m]);
            check($sformatf("pixel%0d", m), 32'(pix_w[m]), e_pix[m]);
            if (we_w[m] === 1'b1) wr_cnt[m]++;
            if (done_w[m] === 1'b1) done_cnt[m]++;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            bit acc;
            acc = rdy_q[m] && s_valid;
            if (!reset_n) begin
                m_busy[m] = 0; m_wait[m] = 0; m_idx[m] = 0; m_total[m] = 0; m_base[m] = 0;
                e_we[m] = 0; e_done[m] = 0; e_addr[m] = 0; e_pix[m] = 0;
            end else begin
                e_we[m]   = acc;
                e_done[m] = acc && (m_idx[m] + 1 == m_total[m]);
                if (acc) begin
                    e_addr[m] = (m_base[m] + m_idx[m]) % 4096;
                    e_pix[m]  = int'(s_data);
                end
                if (!m_busy[m]) begin
                    if (start && !abort) begin
                        m_busy[m]  = 1;
                        m_base[m]  = int'(base_addr);
                        m_total[m] = (count == 0) ? 4096 : int'(count);
                        m_idx[m]   = 0;
                        m_wait[m]  = (m == 1) && !blank;
                    end
                end else if (abort) begin
                    m_busy[m] = 0;
                    m_wait[m] = 0;
                end else if (m_wait[m]) begin
                    if (blank) m_wait[m] = 0;
                end else if (acc) begin
                    m_idx[m]++;
                    if (m_idx[m] == m_total[m]) m_busy[m] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic start_load(logic [11:0] b, logic [12:0] c);
        start = 1'b1;
        base_addr = b;
        count = c;
        s_valid = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    task automatic drain(int bound, bit toggle);
        int k = 0;
        while ((m_busy[0] || m_busy[1]) && k < bound) begin
            blank = 1'b1;
            s_valid = toggle ? k[0] : 1'b1;
            s_data = 12'($urandom);
            cycle();
            k++;
        end
        s_valid = 1'b0;
        cycle();
        cycle();
        check("drain_busy", 32'(busy_w), 32'd0);
    endtask

    task automatic report(string name);
        $display("load %s: writes=%0d/%0d done=%0d/%0d", name, wr_cnt[0], wr_cnt[1],
                 done_cnt[0], done_cnt[1]);
        for (int m = 0; m < 2; m++) begin
            wr_cnt[m] = 0;
            done_cnt[m] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0;
        blank = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        cycle();
        cycle();
        check("reset_outputs", {26'd0, s_ready_w, we_w, busy_w}, 32'd0);
        reset_n = 1'b1;
        cycle();
        report("reset");

        // Basic back-to-back load
        start_load(12'h000, 13'd4);
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data = 12'hA01 + 12'(k);
            cycle();
        end
        drain(20, 0);
        check("basic_writes0", wr_cnt[0], 4);
        check("basic_writes1", wr_cnt[1], 4);
        check("basic_done", done_cnt[0] + done_cnt[1], 2);
        report("basic");

        // Address wrap
        start_load(12'hFFE, 13'd4);
        drain(20, 0);
        check("wrap_writes", wr_cnt[0] + wr_cnt[1], 8);
        report("wrap");

        // Blank gating with pause mid-load
        blank = 1'b0;
        start_load(12'h100, 13'd5);
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        check("gate_no_writes1", wr_cnt[1], 0);
        blank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        blank = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        check("gate_paused_ready", 32'(s_ready_w[1]), 32'd0);
        drain(20, 0);
        check("gate_writes0", wr_cnt[0], 5);
        check("gate_writes1", wr_cnt[1], 5);
        report("blank_gate");

        // Full sprite
        start_load(12'h000, 13'd0);
        drain(5000, 0);
        check("full_writes0", wr_cnt[0], 4096);
        check("full_writes1", wr_cnt[1], 4096);
        check("full_done", done_cnt[0] + done_cnt[1], 2);
        report("full");

        // Abort on the 4th accept attempt, then immediate restart
        start_load(12'h200, 13'd8);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        abort = 1'b1; s_valid = 1'b1; s_data = 12'($urandom);
        cycle();
        abort = 1'b0;
        start_load(12'h300, 13'd2);
        check("abort_writes", wr_cnt[0] + wr_cnt[1], 6);
        check("abort_no_done", done_cnt[0] + done_cnt[1], 0);
        drain(20, 0);
        report("abort");

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; base_addr = 12'h010; count = 13'd3;
        cycle();
        start = 1'b0; abort = 1'b0;
        cycle();
        check("start_abort_idle", 32'(busy_w), 32'd0);
        report("start_abort");

        // Backpressure
        start_load(12'h400, 13'd6);
        drain(40, 1);
        check("bp_writes", wr_cnt[0] + wr_cnt[1], 12);
        report("backpressure");

        // Reset mid-load
        start_load(12'h500, 13'd10);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = 12'($urandom); cycle();
        end
        check("rst_writes", wr_cnt[0] + wr_cnt[1], 6);
        check("rst_no_done", done_cnt[0] + done_cnt[1], 0);
        s_valid = 1'b0;
        report("reset_mid");

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            base_addr = 12'($urandom);
            count     = 13'($urandom_range(1, 24));
            blank     = ($urandom_range(0, 3) != 0);
            s_valid   = $urandom_range(0, 1) != 0;
            s_data    = 12'($urandom);
            reset_n   = ($urandom_range(0, 199) != 0);
            cycle();
        end
        start = 1'b0; abort = 1'b0; reset_n = 1'b1;
        drain(200, 0);
        report("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_sprite_loader.md
Name: enemy_sprite_loader

Overview:
- Write-side companion to the enemy sprite source. Drives that block's sprite-RAM write port (we, addr_w, pixel_in).
- Accepts a valid/ready stream of CD-bit pixels from the processor/DMA side. Writes them to sequential RAM addresses from a programmable base.
- Optionally restricts writes to vertical blanking, so a sprite is never torn mid-frame.
- Reports busy and a one-cycle done pulse.

Parameters:
- CD, 12, pixel colour depth; must match the sprite source.
- ADDR, 12, sprite RAM address width (64x64 = 4096 words).
- BLANK_ONLY, 1, 1 = accept beats only while blank=1; 0 = ignore blank.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle load request; honoured only in IDLE.
- abort, in, 1, terminate the load in progress.
- base_addr, in, ADDR, first RAM address; sampled on an accepted start.
- count, in, ADDR+1, pixels to load; 0 is treated as 2^ADDR; sampled on an accepted start.
- blank, in, 1, vertical blanking from the video sync block.
- s_valid, in, 1, stream beat valid.
- s_data, in, CD, stream pixel.
- s_ready, out, 1, stream beat accepted this cycle when s_valid&&s_ready.
- we, out, 1, sprite RAM write enable.
- addr_w, out, ADDR, sprite RAM write address.
- pixel_in, out, CD, sprite RAM write data.
- busy, out, 1, high in WAIT_BLANK and LOAD.
- done, out, 1, one-cycle pulse on normal completion.

Behaviour:
- Reset: state=IDLE. we=0, addr_w=0, pixel_in=0, busy=0, done=0, s_ready=0. Internal index/remaining=0.
- States:
  - IDLE: start=1 latches base_addr and count, and clears index. Next state is WAIT_BLANK if BLANK_ONLY && !blank, else LOAD. start is ignored in all other states.
  - WAIT_BLANK: s_ready=0. Moves to LOAD on the first cycle blank=1.
  - LOAD: s_ready = !abort && (blank || !BLANK_ONLY). This is combinational; no other output depends combinationally on inputs.
- Accept at cycle t: at t+1, we=1, addr_w=(base+index) mod 2^ADDR, pixel_in=s_data sampled at t. Index then increments.
- we is 0 on every cycle without a preceding accept. addr_w and pixel_in hold their last value when we=0.
- Address wrap: base+index is truncated to ADDR bits. Example: base=0xFFE, count=4 writes 0xFFE, 0xFFF, 0x000, 0x001.
- Blank drops mid-load (BLANK_ONLY=1): s_ready falls in the same cycle and the state stays LOAD (paused). Resumes when blank=1. No beats are lost or duplicated.
- Completion: the accept of beat count-1 moves the state to IDLE. done=1 in the following cycle, coincident with the final we. busy falls in that same cycle.
- abort in WAIT_BLANK or LOAD:
  - Next state is IDLE with no done pulse.
  - A beat offered in the abort cycle is not accepted, because s_ready is forced 0.
  - A write already scheduled from the previous cycle's accept still completes.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort wins, state stays IDLE.
- reset_n=0 mid-load: everything returns to reset values in the next cycle, and no further we pulses occur.
- Throughput: one pixel per cycle while s_valid and blank are held.

Decomposition:
- Shared package (sprite_pkg) holds:
  - SPRITE_H=64, SPRITE_V=64, SPRITE_ADDR=12, COLOR_DEPTH=12.
  - Enum loader_state_t {IDLE, WAIT_BLANK, LOAD}.
- No sub-module required. The write-side register stage (we/addr_w/pixel_in) is inline.

Test Plan:
- Basic load (BLANK_ONLY=0): base=0x000, count=4, s_data=0xA01..0xA04 streamed back-to-back. Expect we on 4 consecutive cycles, addr 0x000–0x003, data matching, done on the 4th we, busy low afterwards.
- Wrap: base=0xFFE, count=4. Expect addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Blanking gate (BLANK_ONLY=1): start with blank=0. Expect s_ready=0 and no we until blank rises. Drop blank after 2 of 5 beats: expect s_ready=0 while paused, resume on blank=1, exactly 5 writes total at consecutive addresses.
- Full sprite: count=0, s_valid held high, blank=1. Expect exactly 4096 we pulses over addr 0x000–0xFFF, then done.
- Abort: count=8, abort asserted on the 4th accept attempt. Expect 3 writes, no 4th accept, no done, IDLE next cycle. A new start is accepted one cycle later.
- Backpressure and reset: s_valid toggles 1/0, expect we only after valid&&ready cycles. Drive reset_n=0 mid-load: expect all outputs 0 the next cycle and no further writes.
